// File: rtl/demultiplexer_if.sv
// rtl/demultiplexer_if.sv - serial-bit producer and word consumer signals of the demultiplexer
interface demultiplexer_if;
  logic       in_valid;
  logic [2:0] address;
  logic       in;
  logic [7:0] data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       seq_err;

  modport master (
    output in_valid, address, in, out_ready,
    input  data, out_valid, overrun, seq_err
  );

  modport slave (
    input  in_valid, address, in, out_ready,
    output data, out_valid, overrun, seq_err
  );
endinterface

// File: rtl/demultiplexer.sv
// rtl/demultiplexer.sv - collects addressed serial bits into 8-bit words behind a one-deep output register
// Optional address-sequence checking is enabled by defining DEMULTIPLEXER_SEQ_CHECK_EN.
module demultiplexer (
  input  logic              clk,
  input  logic              rst,
  demultiplexer_if.slave    bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     r_state;
  logic [7:0] r_shadow;
  logic [7:0] r_data;
  logic       r_out_valid;
  logic       r_overrun;

  logic       w_bad_word;
  logic       w_complete;
  logic [7:0] w_word;

`ifdef DEMULTIPLEXER_SEQ_CHECK_EN
  logic [2:0] r_exp;
  logic       r_bad;
  logic       r_seq_err;
  logic       w_mismatch;

  assign w_mismatch = bus.in_valid && (bus.address != r_exp);
  // A violation on the completing strobe itself already spoils that word.
  assign w_bad_word = r_bad || w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp     <= 3'd0;
      r_bad     <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_seq_err <= w_mismatch;
      if (bus.in_valid) begin
        r_exp <= bus.address + 3'd1;
        r_bad <= (bus.address == 3'd7) ? 1'b0 : w_bad_word;
      end
    end
  end

  assign bus.seq_err = r_seq_err;
`else
  assign w_bad_word  = 1'b0;
  assign bus.seq_err = 1'b0;
`endif

  assign w_complete = bus.in_valid && (bus.address == 3'd7) && !w_bad_word;
  assign w_word     = {bus.in, r_shadow[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_shadow    <= 8'h00;
      r_data      <= 8'h00;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        r_shadow[bus.address] <= bus.in;
      end
      case (r_state)
        EMPTY: begin
          if (w_complete) begin
            r_state     <= FULL;
            r_data      <= w_word;
            r_out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (w_complete) begin
            // Consumer taking the old word on this edge frees the slot for the new one.
            if (bus.out_ready) begin
              r_data <= w_word;
            end else begin
              r_overrun <= 1'b1;
            end
          end else if (bus.out_ready) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.out_valid = r_out_valid;
  assign bus.overrun   = r_overrun;

endmodule
